// File: rtl/fpalu_result_buffer.sv
// rtl/fpalu_result_buffer.sv - result FIFO behind the FP32 multiplier
//
// Buffers {product, flag} results in a DEPTH-entry first-word-fall-through FIFO
// and tracks exception statistics.
// Optional build macro: FPALU_RBUF_DROP_FLAGGED_EN (flagged results are counted
// but never stored; out_flag is tied to 0).
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              producer handshake
//   in_product, in_flag            multiplier result and its exception flag
//   out_valid/out_ready            consumer handshake
//   out_data, out_flag             head entry (read combinationally)
//   level                          occupancy 0..DEPTH
//   flag_sticky, flag_count        exception indicator and saturating count
//   flag_clr                       synchronous clear of the flag statistics
module fpalu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_product,
  input  logic                       in_flag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_flag,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       flag_sticky,
  output logic [CNT_W-1:0]           flag_count,
  input  logic                       flag_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     mem_data [DEPTH];
  logic            push, pop, wr_en;

  assign in_ready  = (level != FULL_LVL);
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef FPALU_RBUF_DROP_FLAGGED_EN
  // Flagged results finish their handshake but never occupy an entry.
  assign wr_en    = push & ~in_flag;
  assign out_flag = 1'b0;
`else
  logic            mem_flag [DEPTH];
  assign wr_en    = push;
  assign out_flag = out_valid ? mem_flag[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (wr_en) mem_flag[wr_ptr] <= in_flag;
  end
`endif

  // Outputs read as zero while empty so the head is clean out of reset.
  assign out_data = out_valid ? mem_data[rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (wr_en) mem_data[wr_ptr] <= in_product;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      state  <= EMPTY;
    end else begin
      state <= state_next;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      level <= level + 1'b1;
      else if (pop && !wr_en) level <= level - 1'b1;
    end
  end

  // State mirrors level; it exists for status visibility.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (wr_en) state_next = PARTIAL;
      PARTIAL: begin
        if (wr_en && !pop && level == FULL_LVL - 1'b1) state_next = FULL;
        else if (pop && !wr_en && level == LW'(1))     state_next = EMPTY;
      end
      FULL:    if (pop) state_next = PARTIAL;
      default: state_next = EMPTY;
    endcase
  end

  // A flagged push in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_sticky <= 1'b0;
      flag_count  <= '0;
    end else if (push && in_flag) begin
      flag_sticky <= 1'b1;
      if (flag_clr)                  flag_count <= CNT_W'(1);
      else if (flag_count != CNT_MAX) flag_count <= flag_count + 1'b1;
    end else if (flag_clr) begin
      flag_sticky <= 1'b0;
      flag_count  <= '0;
    end
  end

endmodule

// File: tb/tb_fpalu_result_buffer.sv
// tb/tb_fpalu_result_buffer.sv - directed self-checking bench for fpalu_result_buffer
module tb_fpalu_result_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_flag;
  logic [31:0] in_product;
  logic        out_valid, out_ready, out_flag;
  logic [31:0] out_data;
  logic [2:0]  level;
  logic        flag_sticky;
  logic [1:0]  flag_count;
  logic        flag_clr;

  int passed = 0;
  int total  = 0;

  logic [31:0] vals [5];

  always #5 clk = ~clk;

  fpalu_result_buffer #(.DEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_flag(in_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flag(out_flag),
    .level(level), .flag_sticky(flag_sticky),
    .flag_count(flag_count), .flag_clr(flag_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000;
    vals[3] = 32'h40800000; vals[4] = 32'h40A00000;

    rst_n = 1'b0; in_valid = 1'b0; in_product = '0; in_flag = 1'b0;
    out_ready = 1'b0; flag_clr = 1'b0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_flag_count", 32'(flag_count), 32'd0);
    check("rst_flag_sticky", 32'(flag_sticky), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // single push, then pop
    in_valid = 1'b1; in_product = 32'h40C00000;
    check("single_no_bypass", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_out_data", out_data, 32'h40C00000);
    check("single_level", 32'(level), 32'd1);
    check("single_out_flag", 32'(out_flag), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_pop_level", 32'(level), 32'd0);
    check("single_pop_valid", 32'(out_valid), 32'd0);

    // fill with back-pressure
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_product = vals[i];
      if (i == 4) check("fill_5th_ready", 32'(in_ready), 32'd0);
      tick();
      if (i == 3) check("fill_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("fill_level", 32'(level), 32'd4);

    // drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", out_data, vals[i]);
      tick();
      if (i == 0) check("drain_ready_back", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b0;
    check("drain_level", 32'(level), 32'd0);

    // concurrent push/pop at level 2 across pointer wrap
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_product = 32'h10000000 + 32'(k);
      tick();
    end
    check("conc_prefill", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_product = 32'h10000000 + 32'(c + 2);
      check("conc_head", out_data, 32'h10000000 + 32'(c));
      tick();
      check("conc_level", 32'(level), 32'd2);
    end
    in_valid = 1'b0;
    for (int c = 10; c < 12; c++) begin
      check("conc_tail", out_data, 32'h10000000 + 32'(c));
      tick();
    end
    out_ready = 1'b0;
    check("conc_empty", 32'(level), 32'd0);

    // asynchronous reset mid-stream at level 3
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_product = 32'h20000000 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    check("mid_level3", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_level", 32'(level), 32'd0);

    // flag accounting, saturation at 3
    out_ready = 1'b1;
    in_valid = 1'b1; in_flag = 1'b1; in_product = 32'h0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) check("flag_cnt_first", 32'(flag_count), 32'd1);
`ifndef FPALU_RBUF_DROP_FLAGGED_EN
      if (k == 0) check("flag_out_flag", 32'(out_flag), 32'd1);
`endif
    end
    in_valid = 1'b0; in_flag = 1'b0;
    check("flag_sticky_set", 32'(flag_sticky), 32'd1);
    check("flag_count_sat", 32'(flag_count), 32'd3);
    tick();
    out_ready = 1'b0;

    flag_clr = 1'b1; in_valid = 1'b1; in_flag = 1'b1;
    tick();
    in_valid = 1'b0; in_flag = 1'b0;
    check("clr_push_count", 32'(flag_count), 32'd1);
    check("clr_push_sticky", 32'(flag_sticky), 32'd1);
    tick();
    flag_clr = 1'b0;
    check("clr_count", 32'(flag_count), 32'd0);
    check("clr_sticky", 32'(flag_sticky), 32'd0);
    in_valid = 1'b1; in_product = 32'h3F000000;
    tick();
    in_valid = 1'b0;
    check("unflagged_no_count", 32'(flag_count), 32'd0);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    check("flag_drained", 32'(level), 32'd0);

`ifdef FPALU_RBUF_DROP_FLAGGED_EN
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    in_valid = 1'b1; in_flag = 1'b1; in_product = 32'h0;
    tick();
    in_flag = 1'b0; in_product = 32'h41200000;
    tick();
    in_valid = 1'b0;
    check("drop_level", 32'(level), 32'd1);
    check("drop_data", out_data, 32'h41200000);
    check("drop_out_flag", 32'(out_flag), 32'd0);
    check("drop_count", 32'(flag_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fpalu_result_buffer.md
Name: fpalu_result_buffer

Overview:
- Downstream stage of the combinational FP32 multiplier.
- Captures each {product[31:0], flag} result under a valid/ready handshake into a small synchronous FIFO and presents it to the consumer, such as the writeback or register-file stage.
- Keeps a sticky exception indicator and a saturating count of flagged results.
- Decouples multiplier issue from consumer back-pressure.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- CNT_W, 8: width of the flagged-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  multiplier result is valid this cycle.
- in_ready  output  1  buffer can accept a result this cycle.
- in_product  input  32  IEEE-754 single-precision product {sign, exp[7:0], frac[22:0]}.
- in_flag  input  1  multiplier exception flag (exponent under/overflow).
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  32  head entry product.
- out_flag  output  1  head entry flag.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- flag_sticky  output  1  set when any flagged result has been accepted since the last clear.
- flag_count  output  CNT_W  number of flagged results accepted; saturating.
- flag_clr  input  1  synchronous clear of flag_sticky and flag_count.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, level=0, out_valid=0, out_data=0, out_flag=0, flag_sticky=0, flag_count=0, state=EMPTY. Storage contents are don't-care.
- Reset asserted mid-transfer discards all entries. No handshake completes in that cycle.
- Handshake rules:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (level != DEPTH). It depends on registered state only, with no combinational path from out_ready.
  - out_valid = (level != 0).
  - out_data/out_flag are read combinationally from mem[rd_ptr] (first-word fall-through).
- Latency: a push into an empty buffer is visible on out_valid/out_data on the next rising edge, i.e. 1 cycle. There is no same-cycle bypass.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. level is tracked separately.
- Occupancy update:
  - push only: level+1.
  - pop only: level-1.
  - push and pop together: level unchanged, both pointers advance.
- Full with pop: in_ready is 0 in that cycle, so no push occurs even if out_ready=1. in_ready rises on the next cycle.
- Empty: out_ready is ignored. rd_ptr and level do not change.
- State machine (encodes level, for status and assertions):
  - EMPTY: on push -> PARTIAL, or -> FULL when DEPTH is 1 (DEPTH is never below 2).
  - PARTIAL: push without pop and level==DEPTH-1 -> FULL. Pop without push and level==1 -> EMPTY. Otherwise stay.
  - FULL: pop -> PARTIAL. Push is impossible.
- Flag accounting, on every push with in_flag=1:
  - flag_sticky <= 1.
  - flag_count <= flag_count+1, saturating at 2^CNT_W-1 with no wrap.
- flag_clr: on the next edge flag_sticky <= 0 and flag_count <= 0. If a flagged push occurs in the same cycle, the new result wins: flag_sticky=1 and flag_count=1.
- The data path does not inspect or modify the product bits.

Optional Feature:
- Macro: FPALU_RBUF_DROP_FLAGGED_EN.
- Defined:
  - A push with in_flag=1 completes its handshake normally (in_ready is honoured) and is counted.
  - The result is NOT written to the FIFO. wr_ptr and level are unchanged.
  - out_flag is tied to 0.
- Undefined: flagged results are stored and delivered with out_flag=1, exactly as described above.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> out_valid=0, in_ready=1, level=0, flag_count=0. Assert rst_n low mid-stream with level=3 -> level=0 and out_valid=0 immediately, before the next edge.
- Single push: in_product=32'h40C00000 (6.0), in_flag=0, out_ready=0 -> next cycle out_valid=1, out_data=32'h40C00000, level=1. Pulse out_ready -> level=0 the cycle after.
- Fill and back-pressure: 5 pushes of 32'h3F800000..32'h40A00000 with out_ready=0, DEPTH=4 -> in_ready=0 after the 4th push, the 5th value is not accepted, level=4. Raise out_ready -> values drain in order 1.0, 2.0, 3.0, 4.0, and in_ready returns 1 one cycle after the first pop.
- Concurrent push/pop at level=2 for 10 cycles -> level stays 2; ordering is preserved across pointer wrap.
- Flag accounting, CNT_W=2:
  - 5 flagged pushes (product 32'h00000000, flag=1) -> flag_sticky=1, flag_count=3 (saturated).
  - flag_clr together with a flagged push -> flag_count=1, flag_sticky=1.
  - flag_clr alone -> 0 and 0.
- With FPALU_RBUF_DROP_FLAGGED_EN: push flagged then unflagged 32'h41200000 -> level=1, out_data=32'h41200000, out_flag=0, flag_count=1.
